// File: rtl/mod_step_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_step_counter_pkg
// Brief    : Shared direction and boundary-mode encodings for the step counter.
// Revision : 1.0 - initial release
// ============================================================================
package mod_step_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : mod_step_counter_pkg
`default_nettype wire

// File: rtl/mod_step_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_step_counter_if
// Brief    : Control and status bundle of the step counter.
// Revision : 1.0 - initial release
// ============================================================================
interface mod_step_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int WRAP_W = 8
);
    logic              enable;
    logic              load;
    logic [WIDTH-1:0]  load_data;
    logic              dir;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              sat_mode;

    logic [WIDTH-1:0]  count;
    logic              at_limit;
    logic              wrap_pulse;
    logic              sat_flag;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output enable, load, load_data, dir, step, limit, sat_mode,
        input  count, at_limit, wrap_pulse, sat_flag, wrap_count
    );

    modport slave (
        input  enable, load, load_data, dir, step, limit, sat_mode,
        output count, at_limit, wrap_pulse, sat_flag, wrap_count
    );

endinterface : mod_step_counter_if
`default_nettype wire

// File: rtl/mod_step_counter_next.sv
`default_nettype none
// ============================================================================
// Module   : mod_step_next
// Brief    : Combinational next-count, wrap and saturation evaluation.
// Revision : 1.0 - initial release
// ============================================================================
module mod_step_next
    import mod_step_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  wire logic [WIDTH-1:0]  count,
    input  wire logic [STEP_W-1:0] step,
    input  wire logic              dir,
    input  wire logic [WIDTH-1:0]  limit,
    input  wire logic              sat_mode,
    output logic      [WIDTH-1:0]  next_count,
    output logic                   wrap,
    output logic                   sat
);

    // Two spare bits keep count+step and limit+1 free of overflow.
    localparam int c_EXT_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;

    logic [c_EXT_W-1:0] w_cnt;
    logic [c_EXT_W-1:0] w_stp;
    logic [c_EXT_W-1:0] w_lim;
    logic [c_EXT_W-1:0] w_mod;
    logic [c_EXT_W-1:0] w_sum;
    logic [c_EXT_W-1:0] w_res;

    assign w_cnt = c_EXT_W'(count);
    assign w_stp = c_EXT_W'(step);
    assign w_lim = c_EXT_W'(limit);
    assign w_mod = w_lim + c_EXT_W'(1);
    assign w_sum = w_cnt + w_stp;

    always_comb begin
        w_res = w_cnt;
        wrap  = 1'b0;
        sat   = 1'b0;
        if (w_cnt > w_lim) begin
            w_res = w_lim;
        end else if (w_stp == '0) begin
            w_res = w_cnt;
        end else if (dir == DIR_UP) begin
            if (w_sum <= w_lim) begin
                w_res = w_sum;
            end else if (sat_mode == MODE_SAT) begin
                w_res = w_lim;
                sat   = 1'b1;
            end else begin
                wrap  = 1'b1;
                w_res = (w_stp > w_mod) ? '0 : (w_sum - w_mod);
            end
        end else begin
            if (w_cnt >= w_stp) begin
                w_res = w_cnt - w_stp;
            end else if (sat_mode == MODE_SAT) begin
                w_res = '0;
                sat   = 1'b1;
            end else begin
                wrap  = 1'b1;
                w_res = (w_stp > w_mod) ? w_lim : (w_cnt + w_mod - w_stp);
            end
        end
    end

    assign next_count = w_res[WIDTH-1:0];

endmodule : mod_step_next
`default_nettype wire

// File: rtl/mod_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_step_counter
// Brief    : Programmable-modulus up/down step counter with wrap/saturate.
// Revision : 1.0 - initial release
// ============================================================================
module mod_step_counter
    import mod_step_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int WRAP_W = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mod_step_counter_if.slave  bus
);

    logic [WIDTH-1:0]  r_count;
    logic              r_at_limit;
    logic              r_wrap_pulse;
    logic              r_sat_flag;
    logic [WRAP_W-1:0] r_wrap_count;

    logic [WIDTH-1:0]  w_next_count;
    logic              w_wrap;
    logic              w_sat;
    logic [WIDTH-1:0]  w_load_val;
    logic [WIDTH-1:0]  w_count_d;

    mod_step_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .count      (r_count),
        .step       (bus.step),
        .dir        (bus.dir),
        .limit      (bus.limit),
        .sat_mode   (bus.sat_mode),
        .next_count (w_next_count),
        .wrap       (w_wrap),
        .sat        (w_sat)
    );

    assign w_load_val = (bus.load_data > bus.limit) ? bus.limit : bus.load_data;

    always_comb begin
        w_count_d = r_count;
        if (bus.load) begin
            w_count_d = w_load_val;
        end else if (bus.enable) begin
            w_count_d = w_next_count;
        end
    end

    // at_limit tracks the value count is about to take, against the current limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_at_limit   <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_sat_flag   <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            r_count    <= w_count_d;
            r_at_limit <= (w_count_d == bus.limit);
            if (bus.load) begin
                r_wrap_pulse <= 1'b0;
                r_sat_flag   <= 1'b0;
                r_wrap_count <= '0;
            end else if (bus.enable) begin
                r_wrap_pulse <= w_wrap;
                if (w_sat) begin
                    r_sat_flag <= 1'b1;
                end
                if (w_wrap && (r_wrap_count != {WRAP_W{1'b1}})) begin
                    r_wrap_count <= r_wrap_count + WRAP_W'(1);
                end
            end else begin
                r_wrap_pulse <= 1'b0;
            end
        end
    end

    assign bus.count      = r_count;
    assign bus.at_limit   = r_at_limit;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.sat_flag   = r_sat_flag;
    assign bus.wrap_count = r_wrap_count;

endmodule : mod_step_counter
`default_nettype wire

// File: tb/tb_mod_step_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_step_counter
// Brief    : Scoreboard bench: directed scenarios plus random traffic vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_step_counter;
    import mod_step_counter_pkg::*;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
    localparam int WRAP_W = 2;
    localparam int WC_MAX = (1 << WRAP_W) - 1;

    typedef struct packed {
        logic [WIDTH-1:0]  count;
        logic              at_limit;
        logic              wrap_pulse;
        logic              sat_flag;
        logic [WRAP_W-1:0] wrap_count;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mod_step_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .WRAP_W(WRAP_W)) bus ();

    mod_step_counter #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   idx_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_push = 0;

    // Reference model state, as plain integers.
    int m_cnt = 0, m_at = 0, m_pulse = 0, m_sat = 0, m_wc = 0;

    function automatic obs_t observed();
        obs_t o;
        o.count      = bus.count;
        o.at_limit   = bus.at_limit;
        o.wrap_pulse = bus.wrap_pulse;
        o.sat_flag   = bus.sat_flag;
        o.wrap_count = bus.wrap_count;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.count      = WIDTH'(m_cnt);
        o.at_limit   = (m_at != 0);
        o.wrap_pulse = (m_pulse != 0);
        o.sat_flag   = (m_sat != 0);
        o.wrap_count = WRAP_W'(m_wc);
        return o;
    endfunction

    task automatic compare(input string name, input int idx, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got count=%0d at=%0b pulse=%0b sat=%0b wc=%0d, expected count=%0d at=%0b pulse=%0b sat=%0b wc=%0d",
                     name, idx, act.count, act.at_limit, act.wrap_pulse, act.sat_flag, act.wrap_count,
                     exp.count, exp.at_limit, exp.wrap_pulse, exp.sat_flag, exp.wrap_count);
        end
    endtask

    // Monitor: every clock the DUT presents a fresh output word.
    always @(posedge clk) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            compare("scoreboard", idx_q.pop_front(), observed(), exp_q.pop_front());
        end
    end

    // Apply one cycle of stimulus and predict the state after the next edge.
    task automatic drive(input bit ld, input bit en, input int ldata, input bit d,
                         input int st, input int lim, input bit sm);
        int m;
        @(negedge clk);
        bus.load      = ld;
        bus.enable    = en;
        bus.load_data = WIDTH'(ldata);
        bus.dir       = d;
        bus.step      = STEP_W'(st);
        bus.limit     = WIDTH'(lim);
        bus.sat_mode  = sm;
        m = lim + 1;
        if (ld) begin
            m_cnt = (ldata > lim) ? lim : ldata;
            m_sat = 0; m_wc = 0; m_pulse = 0;
        end else if (en) begin
            m_pulse = 0;
            if (m_cnt > lim) begin
                m_cnt = lim;
            end else if (st != 0) begin
                if (d == DIR_UP) begin
                    if (m_cnt + st <= lim)       m_cnt = m_cnt + st;
                    else if (sm == MODE_SAT)     begin m_cnt = lim; m_sat = 1; end
                    else                         begin m_cnt = (st > m) ? 0 : (m_cnt + st) % m; m_pulse = 1; end
                end else begin
                    if (m_cnt >= st)             m_cnt = m_cnt - st;
                    else if (sm == MODE_SAT)     begin m_cnt = 0; m_sat = 1; end
                    else                         begin m_cnt = (st > m) ? lim : (m_cnt - st + m) % m; m_pulse = 1; end
                end
            end
            if (m_pulse != 0 && m_wc < WC_MAX) m_wc++;
        end else begin
            m_pulse = 0;
        end
        m_at = (m_cnt == lim) ? 1 : 0;
        exp_q.push_back(model_obs());
        idx_q.push_back(n_push);
        n_push++;
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        m_cnt = 0; m_at = 0; m_pulse = 0; m_sat = 0; m_wc = 0;
        compare("async_reset", n_push, observed(), model_obs());
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.load = 0; bus.enable = 0; bus.load_data = '0; bus.dir = DIR_UP;
        bus.step = '0; bus.limit = 8'd9; bus.sat_mode = MODE_WRAP;
        #12;
        compare("reset_state", -1, observed(), model_obs());
        @(negedge clk);
        reset = 1'b0;

        // Up wrap sequence 0,3,6,9,2
        drive(1, 0, 0, DIR_UP, 0, 9, MODE_WRAP);
        repeat (4) drive(0, 1, 0, DIR_UP, 3, 9, MODE_WRAP);
        drive(0, 0, 0, DIR_UP, 3, 9, MODE_WRAP);

        // Down saturate from 5: 1,0,0
        drive(1, 0, 5, DIR_DOWN, 0, 9, MODE_SAT);
        repeat (3) drive(0, 1, 0, DIR_DOWN, 4, 9, MODE_SAT);
        drive(0, 0, 0, DIR_DOWN, 4, 9, MODE_SAT);

        // Load beats enable and clamps to limit
        drive(1, 1, 200, DIR_UP, 5, 9, MODE_WRAP);

        // Lowered limit pulls count down without a wrap
        drive(1, 0, 7, DIR_UP, 1, 9, MODE_WRAP);
        drive(0, 1, 0, DIR_UP, 1, 4, MODE_WRAP);
        drive(0, 1, 0, DIR_UP, 1, 4, MODE_WRAP);

        // Step equal to the modulus wraps every cycle; wrap_count saturates
        drive(1, 0, 0, DIR_UP, 2, 1, MODE_WRAP);
        repeat (5) drive(0, 1, 0, DIR_UP, 2, 1, MODE_WRAP);

        // Step larger than the modulus, both directions
        drive(1, 0, 1, DIR_UP, 0, 2, MODE_WRAP);
        drive(0, 1, 0, DIR_UP, 9, 2, MODE_WRAP);
        drive(0, 1, 0, DIR_DOWN, 9, 2, MODE_WRAP);

        // Reset mid-count, then count from zero
        drive(1, 0, 6, DIR_UP, 0, 9, MODE_WRAP);
        async_reset();
        drive(0, 1, 0, DIR_UP, 1, 9, MODE_WRAP);

        // Randomized traffic
        begin
            int lim = 9;
            bit sm  = MODE_WRAP;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 19) == 0)
                    lim = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
                if ($urandom_range(0, 15) == 0) sm = ~sm;
                drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), lim, sm);
                if ($urandom_range(0, 249) == 0) async_reset();
            end
        end

        drive(0, 0, 0, DIR_UP, 0, 9, MODE_WRAP);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mod_step_counter
`default_nettype wire
